pool2_ctrl: RTL and testbench

POOL2_CTRL -- requirements
Module: pool2_ctrl

---
 rtl/pool2_ctrl.sv | 137 +++++++++++++
 tb/tb_pool2_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2_ctrl.sv
// 2x2 max-pool sequencer: walks the f4 map window by window, flags the first word
// of each window to the pool datapath and writes one f5 word per window.
module pool2_ctrl #(
    parameter int unsigned MAP_W = 10,
    parameter int unsigned RA_W  = 7,
    parameter int unsigned WA_W  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pool2_start,
    output logic            f4_ren,
    output logic [RA_W-1:0] f4_raddr,
    output logic            pool2_clr,
    output logic            f5_wen,
    output logic [WA_W-1:0] f5_waddr,
    output logic            pool2_busy,
    output logic            pool2_done
);

    localparam int unsigned HALF = MAP_W / 2;
    localparam int unsigned RC_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(HALF - 1);
    localparam logic [WA_W-1:0] WA_LAST = WA_W'(HALF * HALF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [RC_W-1:0] row;
    logic [RC_W-1:0] col;
    logic [1:0]      phase;
    logic            wr_pend;
    logic [WA_W-1:0] wr_cnt;

    logic [RC_W-1:0] row_nx_c;
    logic [RC_W-1:0] col_nx_c;
    logic [1:0]      phase_nx_c;
    logic            last_rd_c;

    // Window word order: top-left, top-right, bottom-left, bottom-right.
    function automatic logic [RA_W-1:0] rd_addr(input logic [RC_W-1:0] rr,
                                                 input logic [RC_W-1:0] cc,
                                                 input logic [1:0]      pp);
        logic [RA_W-1:0] a;
        a = RA_W'(2 * MAP_W) * RA_W'(rr)
          + (RA_W'(cc) << 1)
          + (pp[1] ? RA_W'(MAP_W) : RA_W'(0))
          + RA_W'(pp[0]);
        return a;
    endfunction

    // Position of the read that follows the one currently on f4_raddr.
    always_comb begin
        row_nx_c   = row;
        col_nx_c   = col;
        phase_nx_c = phase + 2'd1;
        last_rd_c  = (row == RC_LAST) && (col == RC_LAST) && (phase == 2'd3);
        if (phase == 2'd3) begin
            if (col == RC_LAST) begin
                col_nx_c = '0;
                row_nx_c = row + RC_W'(1);
            end else begin
                col_nx_c = col + RC_W'(1);
            end
        end
    end

    // Counters track the read being presented; write strobe trails the 4th read by two cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row        <= '0;
            col        <= '0;
            phase      <= '0;
            wr_pend    <= 1'b0;
            wr_cnt     <= '0;
            f4_ren     <= 1'b0;
            f4_raddr   <= '0;
            pool2_clr  <= 1'b0;
            f5_wen     <= 1'b0;
            f5_waddr   <= '0;
            pool2_busy <= 1'b0;
            pool2_done <= 1'b0;
        end else begin
            pool2_done <= 1'b0;
            pool2_clr  <= f4_ren && (phase == 2'd0);
            wr_pend    <= f4_ren && (phase == 2'd3);
            f5_wen     <= wr_pend;
            if (wr_pend) begin
                f5_waddr <= wr_cnt;
                wr_cnt   <= wr_cnt + WA_W'(1);
            end

            case (state)
                IDLE: begin
                    if (pool2_start) begin
                        state      <= READ;
                        f4_ren     <= 1'b1;
                        f4_raddr   <= rd_addr(row, col, phase);
                        pool2_busy <= 1'b1;
                    end
                end
                READ: begin
                    if (last_rd_c) begin
                        state  <= DRAIN;
                        f4_ren <= 1'b0;
                        row    <= '0;
                        col    <= '0;
                        phase  <= '0;
                    end else begin
                        row      <= row_nx_c;
                        col      <= col_nx_c;
                        phase    <= phase_nx_c;
                        f4_raddr <= rd_addr(row_nx_c, col_nx_c, phase_nx_c);
                    end
                end
                DRAIN: begin
                    if (f5_wen && (f5_waddr == WA_LAST)) begin
                        state      <= DONE;
                        pool2_done <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    pool2_busy <= 1'b0;
                    wr_cnt     <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool2_ctrl.sv
// Scoreboard bench for pool2_ctrl: expected reads/clears/writes/done are queued at
// start time; a negedge monitor pops and compares whatever the DUTs present.
module tb_pool2_ctrl;

    localparam int NWIN  = 25;
    localparam int NWIN4 = 4;

    typedef struct {
        int cyc;
        int addr;
    } ev_t;

    logic clk;
    logic rst_n;
    logic pool2_start;
    logic start4;

    logic       f4_ren, pool2_clr, f5_wen, pool2_busy, pool2_done;
    logic [6:0] f4_raddr;
    logic [4:0] f5_waddr;

    logic       f4_ren4, pool2_clr4, f5_wen4, pool2_busy4, pool2_done4;
    logic [3:0] f4_raddr4;
    logic [1:0] f5_waddr4;

    pool2_ctrl #(.MAP_W(10), .RA_W(7), .WA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .pool2_start(pool2_start),
        .f4_ren(f4_ren), .f4_raddr(f4_raddr), .pool2_clr(pool2_clr),
        .f5_wen(f5_wen), .f5_waddr(f5_waddr),
        .pool2_busy(pool2_busy), .pool2_done(pool2_done)
    );

    pool2_ctrl #(.MAP_W(4), .RA_W(4), .WA_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .pool2_start(start4),
        .f4_ren(f4_ren4), .f4_raddr(f4_raddr4), .pool2_clr(pool2_clr4),
        .f5_wen(f5_wen4), .f5_waddr(f5_waddr4),
        .pool2_busy(pool2_busy4), .pool2_done(pool2_done4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // f4 buffer and pool datapath models
    logic [255:0] mem [0:99];
    logic [255:0] f4_rdata;
    logic [255:0] acc;

    function automatic logic [255:0] lane_max(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] m;
        for (int l = 0; l < 16; l++)
            m[l*16 +: 16] = (a[l*16 +: 16] > b[l*16 +: 16]) ? a[l*16 +: 16] : b[l*16 +: 16];
        return m;
    endfunction

    always @(posedge clk) begin
        if (f4_ren) f4_rdata <= mem[f4_raddr];
        acc <= pool2_clr ? f4_rdata : lane_max(acc, f4_rdata);
    end

    // Scoreboard: 0 rd, 1 clr, 2 wr, 3 done (MAP_W=10); 4 rd, 5 wr, 6 done (MAP_W=4)
    ev_t          exp_q [7][$];
    logic [255:0] wd_q[$];
    int           run_s  = -1000;
    int           run4_s = -1000;
    bit           fin_req = 1'b0;
    int           total = 0;
    int           bad   = 0;

    task automatic push(input int kind, input int c, input int a);
        ev_t e;
        e.cyc  = c;
        e.addr = a;
        exp_q[kind].push_back(e);
    endtask

    task automatic push_run(input int s);
        int a0;
        for (int k = 0; k < NWIN; k++) begin
            a0 = 20 * (k / 5) + 2 * (k % 5);
            push(0, s + 1 + 4*k, a0);
            push(0, s + 2 + 4*k, a0 + 1);
            push(0, s + 3 + 4*k, a0 + 10);
            push(0, s + 4 + 4*k, a0 + 11);
            push(1, s + 2 + 4*k, 0);
            push(2, s + 6 + 4*k, k);
            wd_q.push_back(lane_max(lane_max(mem[a0], mem[a0+1]), lane_max(mem[a0+10], mem[a0+11])));
        end
        push(3, s + 4*NWIN + 3, 0);
    endtask

    task automatic push_run4(input int s);
        int a0;
        for (int k = 0; k < NWIN4; k++) begin
            a0 = 8 * (k / 2) + 2 * (k % 2);
            push(4, s + 1 + 4*k, a0);
            push(4, s + 2 + 4*k, a0 + 1);
            push(4, s + 3 + 4*k, a0 + 4);
            push(4, s + 4 + 4*k, a0 + 5);
            push(5, s + 6 + 4*k, k);
        end
        push(6, s + 4*NWIN4 + 3, 0);
    endtask

    task automatic chk_ev(input int kind, input string nm, input int addr);
        ev_t e;
        total++;
        if (exp_q[kind].size() == 0) begin
            bad++;
            $display("FAIL %s unexpected at cycle=%0d addr=%0d", nm, cyc, addr);
        end else begin
            e = exp_q[kind].pop_front();
            if (e.cyc != cyc || e.addr != addr) begin
                bad++;
                $display("FAIL %s got cycle=%0d addr=%0d want cycle=%0d addr=%0d",
                         nm, cyc, addr, e.cyc, e.addr);
            end
        end
    endtask

    task automatic chk_bit(input string nm, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at cycle=%0d got=%0b want=%0b", nm, cyc, got, want);
        end
    endtask

    // Monitor
    initial begin
        logic exp_busy;
        logic exp_busy4;
        forever begin
            @(negedge clk);
            if (fin_req) begin
                for (int k = 0; k < 7; k++) begin
                    total++;
                    if (exp_q[k].size() != 0) begin
                        bad++;
                        $display("FAIL missing_events kind=%0d left=%0d want=0", k, exp_q[k].size());
                    end
                end
                total++;
                if (wd_q.size() != 0) begin
                    bad++;
                    $display("FAIL missing_wdata left=%0d want=0", wd_q.size());
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            if (!rst_n) begin
                total++;
                if ({f4_ren, f4_raddr, pool2_clr, f5_wen, f5_waddr, pool2_busy, pool2_done,
                     f4_ren4, f4_raddr4, pool2_clr4, f5_wen4, f5_waddr4, pool2_busy4, pool2_done4} !== '0) begin
                    bad++;
                    $display("FAIL reset_outputs at cycle=%0d got nonzero want all 0", cyc);
                end
            end
            if (f4_ren)    chk_ev(0, "rd", int'(f4_raddr));
            if (pool2_clr) chk_ev(1, "clr", 0);
            if (f5_wen) begin
                chk_ev(2, "wr", int'(f5_waddr));
                total++;
                if (wd_q.size() == 0) begin
                    bad++;
                    $display("FAIL wdata unexpected at cycle=%0d", cyc);
                end else begin
                    if (acc !== wd_q[0]) begin
                        bad++;
                        $display("FAIL wdata at cycle=%0d got=%h want=%h", cyc, acc, wd_q[0]);
                    end
                    void'(wd_q.pop_front());
                end
            end
            if (pool2_done) chk_ev(3, "done", 0);
            exp_busy = (cyc >= run_s + 1) && (cyc <= run_s + 4*NWIN + 3);
            chk_bit("busy", pool2_busy, exp_busy);

            if (f4_ren4)     chk_ev(4, "rd4", int'(f4_raddr4));
            if (f5_wen4)     chk_ev(5, "wr4", int'(f5_waddr4));
            if (pool2_done4) chk_ev(6, "done4", 0);
            exp_busy4 = (cyc >= run4_s + 1) && (cyc <= run4_s + 4*NWIN4 + 3);
            chk_bit("busy4", pool2_busy4, exp_busy4);
        end
    end

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input bit accept);
        pool2_start = 1'b1;
        if (accept) begin
            push_run(cyc);
            run_s = cyc;
        end
        @(posedge clk);
        #1;
        pool2_start = 1'b0;
    endtask

    // Stimulus
    initial begin
        int s;
        int unsigned v;
        rst_n       = 1'b0;
        pool2_start = 1'b0;
        start4      = 1'b0;
        for (int a = 0; a < 100; a++)
            for (int l = 0; l < 16; l++) begin
                v = 32'(a) * 32'd40503 + 32'(l) * 32'd9973;
                v = v ^ (v >> 5);
                mem[a][l*16 +: 16] = v[15:0];
            end

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // run with ignored starts mid-run and in DONE, then an immediate second run
        s = cyc;
        pulse(1'b1);
        wait_to(s + 50);
        pulse(1'b0);
        wait_to(s + 103);
        pulse(1'b0);
        s = cyc;
        pulse(1'b1);
        wait_to(s + 110);

        // reset mid-run, then a clean full run
        s = cyc;
        pulse(1'b1);
        wait_to(s + 40);
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        wd_q.delete();
        run_s = -1000;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pulse(1'b1);
        repeat (110) @(posedge clk);
        #1;

        // small map
        s = cyc;
        start4 = 1'b1;
        push_run4(s);
        run4_s = s;
        @(posedge clk);
        #1 start4 = 1'b0;
        repeat (25) @(posedge clk);
        #1;

        fin_req = 1'b1;
        repeat (10) @(posedge clk);
        $display("FAIL summary not reached");
        $fatal(1);
    end

endmodule
